// File: rtl/flux_pkg.sv
// Shared definitions for the flux drain path and its upstream tagger.
package flux_pkg;

  typedef enum logic {ARB, HOLD} flux_state_e;

  // Tag width that is able to name every flow index.
  function automatic int flux_tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flux_rr_drain_if.sv
// FIFO-side pop handshake plus the tagged output stream of the drain stage.
interface flux_rr_drain_if import flux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2
);
  localparam int TW = flux_tag_w(FLUX);

  logic [FLUX-1:0]     fifo_empty;
  logic [FLUX-1:0]     fifo_rd;
  logic [WIDTH-1:0]    fifo_data;
  logic [FLUX-1:0]     flow_en;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-TW-1:0] out_data;
  logic [TW-1:0]       out_flow;
  logic                err_tag;

  modport master (
    input  fifo_empty, fifo_data, flow_en, out_ready,
    output fifo_rd, out_valid, out_data, out_flow, err_tag
  );

  modport slave (
    output fifo_empty, fifo_data, flow_en, out_ready,
    input  fifo_rd, out_valid, out_data, out_flow, err_tag
  );
endinterface

// File: rtl/flux_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', modulo N.
module flux_rr_pick import flux_pkg::*; #(
  parameter  int N  = 2,
  localparam int TW = flux_tag_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] last,
  output logic          found,
  output logic [TW-1:0] idx
);
  logic [TW:0] j;

  // One extra bit holds last+k before the single modulo subtract.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = {1'b0, last} + (TW+1)'(k);
      if (j >= (TW+1)'(N)) j = j - (TW+1)'(N);
      if (!found && req[j[TW-1:0]]) begin
        found = 1'b1;
        idx   = j[TW-1:0];
      end
    end
  end
endmodule

// File: rtl/flux_rr_drain.sv
// Round-robin drain: pops one enabled flow per cycle with burst limit,
// checks/strips the tag and feeds a 2-entry output buffer.
module flux_rr_drain import flux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
  parameter int BURST = 4
) (
  input logic            ck,
  input logic            rst,
  flux_rr_drain_if.master bus
);
  localparam int TAG_WIDTH = flux_tag_w(FLUX);
  localparam int PW        = WIDTH - TAG_WIDTH;
  localparam int BCW       = $clog2(BURST + 1);

  flux_state_e          state;
  logic [TAG_WIDTH-1:0] last, cur, pidx, gidx;
  logic [BCW-1:0]       bcnt;
  logic [1:0]           cnt;
  logic [WIDTH-1:0]     buf0, buf1, word;
  logic [FLUX-1:0]      req;
  logic                 pf, space, cont, push, deq, err;

  assign req   = ~bus.fifo_empty & bus.flow_en;
  assign space = (cnt != 2'd2) | bus.out_ready;
  assign cont  = req[cur] & (bcnt < BCW'(BURST));
  assign deq   = (cnt != 2'd0) & bus.out_ready;

  flux_rr_pick #(.N(FLUX)) u_pick (
    .req   (req),
    .last  (last),
    .found (pf),
    .idx   (pidx)
  );

  always_comb begin
    push = 1'b0;
    gidx = cur;
    if (!rst) begin
      if (state == ARB) begin
        push = pf & space;
        gidx = pidx;
      end else begin
        push = cont & space;
      end
    end
  end

  assign bus.fifo_rd = push ? ({{(FLUX-1){1'b0}}, 1'b1} << gidx) : '0;
  // Tag is replaced by the granted index, so a bad tag never misroutes.
  assign word        = {bus.fifo_data[PW-1:0], gidx};

  always_ff @(posedge ck) begin
    if (rst) begin
      state <= ARB;
      last  <= TAG_WIDTH'(FLUX - 1);
      cur   <= '0;
      bcnt  <= BCW'(1);
      cnt   <= 2'd0;
      buf0  <= '0;
      buf1  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ARB: if (push) begin
          cur  <= pidx;
          last <= pidx;
          bcnt <= BCW'(1);
          if (BURST > 1) state <= HOLD;
        end
        HOLD: begin
          // Losing the grant costs one idle cycle before re-arbitration.
          if (!cont)     state <= ARB;
          else if (push) bcnt  <= bcnt + 1'b1;
        end
        default: state <= ARB;
      endcase

      if (push && (bus.fifo_data[WIDTH-1 -: TAG_WIDTH] != gidx)) err <= 1'b1;

      case ({push, deq})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= word;
          else             buf1 <= word;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) buf0 <= word;
          else begin
            buf0 <= buf1;
            buf1 <= word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_data  = buf0[WIDTH-1 -: PW];
  assign bus.out_flow  = buf0[TAG_WIDTH-1:0];
  assign bus.err_tag   = err;
endmodule

// File: tb/tb_flux_rr_drain.sv
// Directed bench: queue-based FIFO model feeding two drain configurations,
// output stream checked against a scoreboard of expected words.
module tb_flux_rr_drain;
  import flux_pkg::*;

  typedef struct packed {
    logic [6:0] d;
    logic [1:0] f;
  } exp_t;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst_a, rst_b;
  flux_rr_drain_if #(.WIDTH(8), .FLUX(2)) ia ();
  flux_rr_drain_if #(.WIDTH(8), .FLUX(3)) ib ();

  flux_rr_drain #(.WIDTH(8), .FLUX(2), .BURST(2)) dut_a (.ck(ck), .rst(rst_a), .bus(ia.master));
  flux_rr_drain #(.WIDTH(8), .FLUX(3), .BURST(1)) dut_b (.ck(ck), .rst(rst_b), .bus(ib.master));

  logic [7:0] fq [3][$];
  logic [7:0] head [3];
  logic [2:0] emp, pend, en;
  logic       ra, rb, rdy, sel;
  exp_t       sb [$];
  int         nvec, nerr;

  assign ia.fifo_empty = emp[1:0];
  assign ib.fifo_empty = emp;

  always_comb begin
    ia.fifo_data = '0;
    for (int i = 0; i < 2; i++) if (ia.fifo_rd[i]) ia.fifo_data = head[i];
  end
  always_comb begin
    ib.fifo_data = '0;
    for (int i = 0; i < 3; i++) if (ib.fifo_rd[i]) ib.fifo_data = head[i];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fpush(input int f, input logic [7:0] w);
    fq[f].push_back(w);
  endtask

  task automatic epush(input int f, input logic [7:0] w);
    exp_t e;
    e.d = sel ? {1'b0, w[5:0]} : w[6:0];
    e.f = 2'(f);
    sb.push_back(e);
  endtask

  // One clock: retire last cycle's pops, drive inputs, check strobe and output.
  task automatic cyc(input logic [2:0] erd);
    logic [2:0] rd;
    logic [6:0] od;
    logic [1:0] of;
    logic       ov;
    exp_t       e;
    @(negedge ck);
    for (int i = 0; i < 3; i++) if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    for (int i = 0; i < 3; i++) begin
      emp[i]  = (fq[i].size() == 0);
      head[i] = emp[i] ? 8'h00 : fq[i][0];
    end
    rst_a = ra; rst_b = rb;
    ia.out_ready = rdy; ib.out_ready = rdy;
    ia.flow_en = en[1:0]; ib.flow_en = en;
    #1;
    rd = sel ? ib.fifo_rd : {1'b0, ia.fifo_rd};
    chk("fifo_rd", 16'(rd), 16'(erd));
    ov = sel ? ib.out_valid : ia.out_valid;
    od = sel ? {1'b0, ib.out_data} : ia.out_data;
    of = sel ? ib.out_flow : {1'b0, ia.out_flow};
    if (ov && rdy) begin
      chk("sb_has_entry", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 16'(od), 16'(e.d));
        chk("out_flow", 16'(of), 16'(e.f));
      end
    end
    pend = ib.fifo_rd | {1'b0, ia.fifo_rd};
  endtask

  initial begin
    nvec = 0; nerr = 0;
    emp = 3'b111; pend = '0; en = 3'b111;
    ra = 1'b1; rb = 1'b1; rdy = 1'b1; sel = 1'b0;
    for (int i = 0; i < 3; i++) head[i] = 8'h00;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1;
    ia.flow_en = 2'b11; ib.flow_en = 3'b111;

    // reset state
    cyc(3'b000); cyc(3'b000);
    chk("rst_out_valid", 16'(ia.out_valid), 16'd0);
    chk("rst_out_data",  16'(ia.out_data),  16'd0);
    chk("rst_out_flow",  16'(ia.out_flow),  16'd0);
    chk("rst_err_tag",   16'(ia.err_tag),   16'd0);
    chk("rst_cnt",       16'(dut_a.cnt),    16'd0);
    chk("rst_last",      16'(dut_a.last),   16'd1);

    // two flows of 3 words, BURST=2: 0,0,-,1,1,-,0,-,1
    fpush(0, 8'h01); fpush(0, 8'h02); fpush(0, 8'h03);
    fpush(1, 8'h91); fpush(1, 8'h92); fpush(1, 8'h93);
    epush(0, 8'h01); epush(0, 8'h02); epush(1, 8'h91);
    epush(1, 8'h92); epush(0, 8'h03); epush(1, 8'h93);
    ra = 1'b0;
    cyc(3'b001);
    chk("lat_before", 16'(ia.out_valid), 16'd0);
    cyc(3'b001);
    chk("lat_after", 16'(ia.out_valid), 16'd1);
    cyc(3'b000); cyc(3'b010); cyc(3'b010); cyc(3'b000);
    cyc(3'b001); cyc(3'b000); cyc(3'b010); cyc(3'b000); cyc(3'b000);
    chk("rr_sb_drained", 16'(sb.size()), 16'd0);

    // disabled flow is never granted
    en = 3'b001;
    fpush(1, 8'h94);
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000);
      chk("mask_out_valid", 16'(ia.out_valid), 16'd0);
    end

    // backpressure: two pops fill the buffer, then stall
    rdy = 1'b0;
    for (int w = 8'h21; w <= 8'h25; w++) begin
      fpush(0, 8'(w)); epush(0, 8'(w));
    end
    cyc(3'b001); cyc(3'b001); cyc(3'b000); cyc(3'b000); cyc(3'b000);
    chk("bp_cnt", 16'(dut_a.cnt), 16'd2);
    chk("bp_out_data", 16'(ia.out_data), 16'h21);
    rdy = 1'b1;
    cyc(3'b001); cyc(3'b001); cyc(3'b000); cyc(3'b001); cyc(3'b000); cyc(3'b000);
    chk("bp_sb_drained", 16'(sb.size()), 16'd0);

    // tag mismatch: forwarded with tag stripped, err_tag sticky
    fpush(0, 8'h85); epush(0, 8'h85);
    cyc(3'b001);
    chk("err_before", 16'(ia.err_tag), 16'd0);
    cyc(3'b000);
    chk("err_rise", 16'(ia.err_tag), 16'd1);
    fpush(0, 8'h06); epush(0, 8'h06);
    cyc(3'b001); cyc(3'b000); cyc(3'b000);
    chk("err_sticky", 16'(ia.err_tag), 16'd1);

    // reset during HOLD with a full buffer
    rdy = 1'b0;
    fpush(0, 8'h31); fpush(0, 8'h32); fpush(0, 8'h33); fpush(0, 8'h34);
    cyc(3'b001); cyc(3'b001);
    ra = 1'b1; en = 3'b011;
    cyc(3'b000);
    chk("mid_state", 16'(dut_a.state), 16'(HOLD));
    chk("mid_cnt", 16'(dut_a.cnt), 16'd2);
    cyc(3'b000);
    chk("mid_out_valid", 16'(ia.out_valid), 16'd0);
    chk("mid_err_clr", 16'(ia.err_tag), 16'd0);
    epush(0, 8'h33); epush(0, 8'h34); epush(1, 8'h94);
    ra = 1'b0; rdy = 1'b1;
    cyc(3'b001); cyc(3'b001); cyc(3'b000); cyc(3'b010); cyc(3'b000); cyc(3'b000);
    chk("mid_sb_drained", 16'(sb.size()), 16'd0);

    // FLUX=3, BURST=1: 0,1,2,0,1,2 without bubbles
    sel = 1'b1; ra = 1'b1; en = 3'b111;
    cyc(3'b000);
    chk("b_rst_last", 16'(dut_b.last), 16'd2);
    fpush(0, 8'h01); fpush(0, 8'h02);
    fpush(1, 8'h41); fpush(1, 8'h42);
    fpush(2, 8'h81); fpush(2, 8'h82);
    epush(0, 8'h01); epush(1, 8'h41); epush(2, 8'h81);
    epush(0, 8'h02); epush(1, 8'h42); epush(2, 8'h82);
    rb = 1'b0;
    cyc(3'b001); cyc(3'b010); cyc(3'b100); cyc(3'b001);
    chk("b_last_2", 16'(dut_b.last), 16'd2);
    cyc(3'b010);
    chk("b_last_wrap", 16'(dut_b.last), 16'd0);
    cyc(3'b100); cyc(3'b000); cyc(3'b000);
    chk("b_sb_drained", 16'(sb.size()), 16'd0);
    chk("b_err_tag", 16'(ib.err_tag), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/flux_rr_drain.md
# flux_rr_drain

Round-robin drain stage directly downstream of the shared-memory multi-flow FIFO. Every cycle it picks one non-empty, enabled flow, pops one word with a one-hot read strobe and captures the FIFO's same-cycle output word. It checks the word's tag, strips it, and presents payload plus flow index on a valid/ready stream through a 2-entry output buffer. Consecutive pops from one flow are limited to `BURST` before the grant rotates.

## Interface
- `WIDTH`, 8: FIFO word width, tag included (tag = top `TAG_WIDTH` bits).
- `FLUX`, 2: number of flows; must be ≥2.
- `BURST`, 4: maximum consecutive pops from one flow per grant, ≥1.
- `TAG_WIDTH`, derived `$clog2(FLUX)`: not overridable.
- `ck`  in  1  clock; single clock domain, all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_empty`  in  FLUX  per-flow empty from the FIFO.
- `fifo_rd`  out  FLUX  one-hot pop strobe to the FIFO; combinational.
- `fifo_data`  in  WIDTH  FIFO head word of the flow strobed in the same cycle.
- `flow_en`  in  FLUX  per-flow enable mask; a disabled flow is never granted.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid & out_ready`.
- `out_data`  out  WIDTH-TAG_WIDTH  payload, tag stripped.
- `out_flow`  out  TAG_WIDTH  flow index the word was popped from.
- `err_tag`  out  1  sticky: a popped word's tag differed from the granted flow.

## Operation
- `fifo_rd` is one-hot or zero. It is never asserted for a flow with `fifo_empty=1` or `flow_en=0`.
- Issue condition: `space = (cnt != 2) | out_ready`, where `cnt` is the buffer occupancy, 0..2. No pop without `space`.
- FSM states: ARB and HOLD. Registers: `last` (last granted flow), `cur`, and `bcnt` (1..BURST).
- ARB: search flows `last+1, last+2, …` modulo FLUX for the first one with `!fifo_empty & flow_en`.
  - If a flow is found and `space` holds: pop it, `cur←flow`, `last←flow`, `bcnt←1`.
  - Then go to HOLD if `BURST>1`, else stay in ARB.
  - If nothing is found or there is no `space`: no pop, stay in ARB.
- HOLD, flow `cur` continues when `!fifo_empty[cur] & flow_en[cur] & bcnt<BURST`:
  - With `space`: pop `cur`, `bcnt←bcnt+1`, stay in HOLD.
  - Without `space`: no pop, stay in HOLD (stall keeps the grant).
- HOLD, flow `cur` cannot continue: no pop this cycle, go to ARB. This costs one bubble cycle, which is required.
- Popped word is written into the buffer tail as `{fifo_data[WIDTH-TAG_WIDTH-1:0], cur}`.
- If `fifo_data[WIDTH-1 -: TAG_WIDTH] != cur`: `err_tag←1`, and the word is still forwarded.
- Buffer: FIFO order, 2 entries. Head drives `out_*`. Simultaneous push and pop with `cnt=2` is legal and `cnt` stays 2.
- `last` wraps from FLUX-1 to 0. Flow indices ≥FLUX (non-power-of-2 FLUX) are never granted.

## Timing
- Reset values (`rst`=1 at an edge): `out_valid=0`, `out_data=0`, `out_flow=0`, `err_tag=0`, `cnt=0`, state ARB, `bcnt=1`, `cur=0`, `last=FLUX-1`. With `last=FLUX-1`, the first search starts at flow 0.
- While `rst`=1, `fifo_rd=0` regardless of other inputs.
- Reset mid-burst discards the buffer contents. Words already popped are lost, which is accepted.
- Latency: a word popped in cycle N gives `out_valid=1` with that word in cycle N+1 (buffer empty before).
- Throughput: one word per cycle while `out_ready=1` and the granted flow stays non-empty.
- Combinational paths: `fifo_empty`, `flow_en`, `out_ready` → `fifo_rd`. No path from `fifo_data` to any output.
- `out_*` are stable while `out_valid & !out_ready`.

## Structure
- Shared package `flux_pkg`: FSM state enum (ARB, HOLD) and the tag-width helper function, both reused by the FIFO's upstream tagger.
- Sub-module `flux_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last`; outputs are found and index.
- The 2-entry buffer stays inline in this block.

## Test plan
- Reset, then flows 0 and 1 each hold 3 words, `BURST=2`, `out_ready=1`:
  - Pop order 0,0,bubble,1,1,bubble,0,bubble,1.
  - `out_flow` follows that sequence; first `out_valid` appears one cycle after the first `fifo_rd`.
- Flow 1 only non-empty, `flow_en=2'b01`: `fifo_rd` stays 0 and `out_valid` stays 0.
- Hold `out_ready=0` with flow 0 holding 5 words:
  - Exactly 2 pops occur, then `fifo_rd=0` and `cnt=2`.
  - On release, `fifo_rd=01` in the same cycle as `out_ready=1`.
- Flow 0 word with tag 1 (WIDTH=8, `fifo_data=8'h85`) popped under grant 0: `out_data=7'h05`, `out_flow=0`, `err_tag` rises and stays 1 until `rst`.
- Reset asserted during HOLD with `cnt=2`: next cycle `out_valid=0`, `fifo_rd=0`; after release, arbitration restarts at flow 0.
- FLUX=3, all flows non-empty, `BURST=1`: grant order 0,1,2,0,… with no bubbles; `last` wraps from 2 to 0.
